mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Sequencer between the cache arbiter's memory port and the 64-bit system memory bus. Takes one 512-bit cache-line request at a time (read or write), requests the bus, moves the line as eight 64-bit beats, and returns a one-cycle completion pulse (plus the assembled line for reads) to the arbiter. Sits directly downstream of the arbiter, upstream of the memory/bus interface.

## Interface
Parameters:
- ADDR_W, 64, address width
- LINE_W, 512, cache line width
- BEAT_W, 64, bus data width; beats per line = LINE_W/BEAT_W = 8

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mem_req  in  1  arbiter request, level
- mem_wr_en  in  1  1 = write line, 0 = read line
- mem_address  in  ADDR_W  line address (low 6 bits ignored)
- mem_data_in  in  LINE_W  write line data
- mem_data_out  out  LINE_W  last read line
- mem_complete  out  1  one-cycle done pulse
- busy  out  1  high in any non-IDLE state
- bus_req  out  1  bus request
- bus_grant  in  1  bus grant
- bus_addr  out  ADDR_W  line-aligned address
- bus_wr  out  1  transaction direction
- bus_wdata  out  BEAT_W  write beat
- bus_wvalid  out  1  write beat valid
- bus_wready  in  1  bus accepts write beat
- bus_rvalid  in  1  read beat valid
- bus_rdata  in  BEAT_W  read beat

## Operation
- States: IDLE, REQ, WDATA, RDATA, DONE. 3-bit beat counter.
- IDLE: if mem_req=1, capture mem_address with bits [5:0] forced to 0, mem_data_in, mem_wr_en; counter=0; go REQ. Otherwise stay.
- REQ: bus_req=1, bus_addr/bus_wr driven from captured values. bus_grant=1 -> WDATA if write, else RDATA. bus_req drops the cycle after grant is sampled.
- WDATA: bus_wvalid=1, bus_wdata = captured line bits [64k+63:64k], k=counter. Beat transfers when bus_wvalid && bus_wready; counter increments. Transfer of beat 7 -> DONE.
- RDATA: each cycle bus_rvalid=1, store bus_rdata into line-buffer slot k, increment counter; gaps allowed. Beat 7 received -> DONE.
- DONE: mem_complete=1 for exactly one cycle; on a read, mem_data_out is loaded with the full buffer in this cycle. Next state IDLE.
- Beat order: beat 0 (bits [63:0]) first, beat 7 last. Counter wraps 7->0 on the last beat.
- mem_req, mem_address, mem_data_in ignored outside IDLE; bus_grant ignored outside REQ; bus_rvalid ignored outside RDATA; bus_wready ignored outside WDATA.
- mem_req still high in the IDLE cycle after mem_complete is a new request (arbiter drops mem_req on seeing mem_complete).
- Writes do not modify mem_data_out. Partial read data never appears on mem_data_out.
- bus_addr and bus_wr hold their captured values from REQ through DONE; 0 in IDLE.

## Timing
- Reset: state IDLE, counter 0; mem_data_out, mem_complete, busy, bus_req, bus_addr, bus_wr, bus_wdata, bus_wvalid all 0. Reset mid-transaction aborts immediately, no mem_complete, buffered read data discarded.
- All outputs registered or decoded from state/registers only; no combinational path from inputs to outputs.
- Write, grant and wready always high: accept cycle 0, bus_req cycle 1 (grant sampled), beats cycles 2-9, mem_complete cycle 10.
- Read: last bus_rvalid sampled at cycle r -> mem_complete and new mem_data_out at r+1.
- Minimum back-to-back spacing: accept in cycle after DONE.

## Test plan
- Write, address 0x1000_0037, line = beat k holds 64'h1111_1111_1111_1111*(k+1), grant and wready high -> bus_addr 0x1000_0000, bus_wr=1, beats in order cycles 2-9, mem_complete cycle 10 only.
- Read, address 0x2040, grant delayed 3 cycles, bus_rvalid with gaps after beats 2 and 5, data 64'hA0+k -> mem_data_out = {beats 7..0} on completion cycle, single-cycle mem_complete.
- Write with bus_wready low for 4 cycles at beat 3 -> bus_wdata holds beat 3 stable with bus_wvalid=1, no beat skipped or duplicated.
- Reset asserted after read beat 4 -> next cycle all outputs 0, state IDLE, no mem_complete, mem_data_out keeps 0/prior reset value; following read completes normally.
- mem_req held high through completion of a read then write request queued -> second transaction accepted in the IDLE cycle after DONE; stray bus_rvalid/bus_grant pulses in IDLE have no effect.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// Cache-line sequencer between the arbiter memory port and the 64-bit system bus.
// Moves one line per request as LINE_W/BEAT_W beats, then pulses mem_complete for one cycle.
module mem_bus_ctrl #(
    parameter int ADDR_W = 64,
    parameter int LINE_W = 512,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [LINE_W-1:0] mem_data_in,
    output logic [LINE_W-1:0] mem_data_out,
    output logic              mem_complete,
    output logic              busy,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_wr,
    output logic [BEAT_W-1:0] bus_wdata,
    output logic              bus_wvalid,
    input  logic              bus_wready,
    input  logic              bus_rvalid,
    input  logic [BEAT_W-1:0] bus_rdata
);

    localparam int unsigned BEATS  = LINE_W / BEAT_W;
    localparam int unsigned CNT_W  = $clog2(BEATS);
    localparam int unsigned OFFS_W = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~{{(ADDR_W-OFFS_W){1'b0}}, {OFFS_W{1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WDATA,
        RDATA,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [LINE_W-1:0] wline_q;
    logic [LINE_W-1:0] rbuf_q;
    logic [LINE_W-1:0] data_out_q;
    logic              accept;
    logic              w_xfer;
    logic              r_xfer;
    logic              last_beat;

    always_comb begin
        accept    = (state == IDLE) && mem_req;
        w_xfer    = (state == WDATA) && bus_wready;
        r_xfer    = (state == RDATA) && bus_rvalid;
        last_beat = (cnt == CNT_W'(BEATS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_req) state_nxt = REQ;
            REQ:     if (bus_grant) state_nxt = wr_q ? WDATA : RDATA;
            WDATA:   if (w_xfer && last_beat) state_nxt = DONE;
            RDATA:   if (r_xfer && last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            data_out_q <= '0;
        end else begin
            if (accept) begin
                cnt    <= '0;
                addr_q <= mem_address & LINE_MASK;
                wr_q   <= mem_wr_en;
            end else if (w_xfer || r_xfer) begin
                cnt <= cnt + CNT_W'(1);
            end
            // The final beat goes straight into the output line so no partial line is ever visible.
            if (r_xfer && last_beat) begin
                data_out_q <= {bus_rdata, rbuf_q[LINE_W-BEAT_W-1:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wline_q <= mem_data_in;
        end
        if (r_xfer) begin
            rbuf_q[cnt*BEAT_W +: BEAT_W] <= bus_rdata;
        end
    end

    always_comb begin
        busy         = (state != IDLE);
        bus_req      = (state == REQ);
        mem_complete = (state == DONE);
        bus_wvalid   = (state == WDATA);
        bus_addr     = (state != IDLE) ? addr_q : '0;
        bus_wr       = (state != IDLE) && wr_q;
        bus_wdata    = (state == WDATA) ? wline_q[cnt*BEAT_W +: BEAT_W] : '0;
        mem_data_out = data_out_q;
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized bench for mem_bus_ctrl: transaction-level model of beats, latency and returned lines.
module tb_mem_bus_ctrl;

    localparam int ADDR_W = 64;
    localparam int LINE_W = 512;
    localparam int BEAT_W = 64;

    typedef logic [LINE_W-1:0] v_t;

    logic              clk;
    logic              rst;
    logic              mem_req;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_data_in;
    logic [LINE_W-1:0] mem_data_out;
    logic              mem_complete;
    logic              busy;
    logic              bus_req;
    logic              bus_grant;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_wr;
    logic [BEAT_W-1:0] bus_wdata;
    logic              bus_wvalid;
    logic              bus_wready;
    logic              bus_rvalid;
    logic [BEAT_W-1:0] bus_rdata;

    int   n_checks;
    int   n_pass;
    v_t   exp_out;
    bit   in_done;

    mem_bus_ctrl #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W),
        .BEAT_W(BEAT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_wr_en   (mem_wr_en),
        .mem_address (mem_address),
        .mem_data_in (mem_data_in),
        .mem_data_out(mem_data_out),
        .mem_complete(mem_complete),
        .busy        (busy),
        .bus_req     (bus_req),
        .bus_grant   (bus_grant),
        .bus_addr    (bus_addr),
        .bus_wr      (bus_wr),
        .bus_wdata   (bus_wdata),
        .bus_wvalid  (bus_wvalid),
        .bus_wready  (bus_wready),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input v_t got, input v_t exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic v_t rand_line();
        v_t l;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Inputs the controller must ignore while busy get fresh junk every cycle.
    task automatic scramble();
        mem_req     = 1'($urandom_range(0, 1));
        mem_address = {$urandom, $urandom};
        mem_data_in = rand_line();
        mem_wr_en   = 1'($urandom_range(0, 1));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, v_t'(busy), v_t'(0));
        check_eq({tag, "_bus_req"}, v_t'(bus_req), v_t'(0));
        check_eq({tag, "_bus_addr"}, v_t'(bus_addr), v_t'(0));
        check_eq({tag, "_bus_wr"}, v_t'(bus_wr), v_t'(0));
        check_eq({tag, "_bus_wdata"}, v_t'(bus_wdata), v_t'(0));
        check_eq({tag, "_bus_wvalid"}, v_t'(bus_wvalid), v_t'(0));
        check_eq({tag, "_complete"}, v_t'(mem_complete), v_t'(0));
        check_eq({tag, "_data_out"}, mem_data_out, v_t'(0));
    endtask

    task automatic idle(input int n);
        mem_req = 1'b0;
        in_done = 1'b0;
        repeat (n) begin
            bus_grant  = 1'($urandom_range(0, 1));
            bus_rvalid = 1'($urandom_range(0, 1));
            bus_wready = 1'($urandom_range(0, 1));
            bus_rdata  = {$urandom, $urandom};
            @(negedge clk);
            check_eq("idle_busy", v_t'(busy), v_t'(0));
            check_eq("idle_bus_req", v_t'(bus_req), v_t'(0));
            check_eq("idle_complete", v_t'(mem_complete), v_t'(0));
            check_eq("idle_bus_addr", v_t'(bus_addr), v_t'(0));
            check_eq("idle_wvalid", v_t'(bus_wvalid), v_t'(0));
            check_eq("idle_data_out", mem_data_out, exp_out);
        end
    endtask

    // Drives the request, holds it through the IDLE cycle, then runs the REQ phase.
    task automatic start_txn(input bit wr, input logic [63:0] addr, input v_t line,
                             input int gdly, output int cyc);
        mem_req     = 1'b1;
        mem_wr_en   = wr;
        mem_address = addr;
        mem_data_in = line;
        if (in_done) @(negedge clk);
        in_done = 1'b0;
        check_eq("accept_busy", v_t'(busy), v_t'(0));
        cyc = 0;
        @(negedge clk);
        cyc++;
        scramble();
        for (int g = 0; g <= gdly; g++) begin
            check_eq("req_bus_req", v_t'(bus_req), v_t'(1));
            check_eq("req_busy", v_t'(busy), v_t'(1));
            check_eq("req_bus_addr", v_t'(bus_addr), v_t'(addr & ~64'h3f));
            check_eq("req_bus_wr", v_t'(bus_wr), v_t'(wr));
            check_eq("req_wvalid", v_t'(bus_wvalid), v_t'(0));
            check_eq("req_complete", v_t'(mem_complete), v_t'(0));
            bus_grant  = (g == gdly);
            bus_wready = 1'($urandom_range(0, 1));
            bus_rvalid = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            scramble();
        end
    endtask

    task automatic do_write(input logic [63:0] addr, input v_t line, input int gdly,
                            input logic [7:0] smask, input int slen, input bit rnd);
        int cyc, k, stalls, sdone;
        logic rdy;
        start_txn(1'b1, addr, line, gdly, cyc);
        k = 0; stalls = 0; sdone = 0;
        while (k < 8) begin
            check_eq("wr_bus_req", v_t'(bus_req), v_t'(0));
            check_eq("wr_wvalid", v_t'(bus_wvalid), v_t'(1));
            check_eq("wr_wdata", v_t'(bus_wdata), v_t'(line[k*BEAT_W +: BEAT_W]));
            check_eq("wr_bus_addr", v_t'(bus_addr), v_t'(addr & ~64'h3f));
            check_eq("wr_bus_wr", v_t'(bus_wr), v_t'(1));
            check_eq("wr_complete", v_t'(mem_complete), v_t'(0));
            if (rnd) rdy = ($urandom_range(0, 3) != 0);
            else     rdy = !(smask[k] && sdone < slen);
            if (!rdy) begin stalls++; sdone++; end
            else      sdone = 0;
            bus_wready = rdy;
            bus_grant  = 1'($urandom_range(0, 1));
            bus_rvalid = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            scramble();
            if (rdy) k++;
        end
        check_eq("wr_done_complete", v_t'(mem_complete), v_t'(1));
        check_eq("wr_latency", v_t'(cyc), v_t'(2 + gdly + 8 + stalls));
        check_eq("wr_done_wvalid", v_t'(bus_wvalid), v_t'(0));
        check_eq("wr_done_busy", v_t'(busy), v_t'(1));
        check_eq("wr_done_addr", v_t'(bus_addr), v_t'(addr & ~64'h3f));
        check_eq("wr_data_out_kept", mem_data_out, exp_out);
        mem_req = 1'b0;
        in_done = 1'b1;
    endtask

    task automatic do_read(input logic [63:0] addr, input v_t line, input int gdly,
                           input logic [7:0] gmask, input bit rnd, input int abort_at);
        int cyc, k, gaps;
        bit gap_taken;
        logic vld;
        start_txn(1'b0, addr, line, gdly, cyc);
        k = 0; gaps = 0; gap_taken = 0;
        while (k < 8) begin
            if (k == abort_at) begin
                rst     = 1'b1;
                mem_req = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check_all_zero("abort");
                exp_out = '0;
                in_done = 1'b0;
                return;
            end
            check_eq("rd_bus_req", v_t'(bus_req), v_t'(0));
            check_eq("rd_wvalid", v_t'(bus_wvalid), v_t'(0));
            check_eq("rd_bus_addr", v_t'(bus_addr), v_t'(addr & ~64'h3f));
            check_eq("rd_bus_wr", v_t'(bus_wr), v_t'(0));
            check_eq("rd_complete", v_t'(mem_complete), v_t'(0));
            check_eq("rd_no_partial", mem_data_out, exp_out);
            if (rnd) vld = ($urandom_range(0, 2) != 0);
            else     vld = !(gmask[k] && !gap_taken);
            if (!vld) begin gaps++; gap_taken = 1; end
            else      gap_taken = 0;
            bus_rvalid = vld;
            bus_rdata  = vld ? line[k*BEAT_W +: BEAT_W] : {$urandom, $urandom};
            bus_grant  = 1'($urandom_range(0, 1));
            bus_wready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            scramble();
            if (vld) k++;
        end
        exp_out = line;
        check_eq("rd_done_complete", v_t'(mem_complete), v_t'(1));
        check_eq("rd_latency", v_t'(cyc), v_t'(2 + gdly + 8 + gaps));
        check_eq("rd_line", mem_data_out, exp_out);
        check_eq("rd_done_busy", v_t'(busy), v_t'(1));
        mem_req = 1'b0;
        in_done = 1'b1;
    endtask

    initial begin
        v_t line;
        n_checks    = 0;
        n_pass      = 0;
        exp_out     = '0;
        in_done     = 1'b0;
        rst         = 1'b1;
        mem_req     = 1'b0;
        mem_wr_en   = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        bus_grant   = 1'b0;
        bus_wready  = 1'b0;
        bus_rvalid  = 1'b0;
        bus_rdata   = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // Nominal write: ready bus, line-offset bits stripped from the address.
        for (int k = 0; k < 8; k++) line[k*BEAT_W +: BEAT_W] = 64'h1111_1111_1111_1111 * 64'(k + 1);
        do_write(64'h1000_0037, line, 0, 8'h00, 0, 1'b0);
        idle(2);

        // Read with late grant and one-cycle gaps after beats 2 and 5.
        for (int k = 0; k < 8; k++) line[k*BEAT_W +: BEAT_W] = 64'hA0 + 64'(k);
        do_read(64'h2040, line, 3, 8'b0100_1000, 1'b0, 8);
        idle(1);

        // Write with wready low for 4 cycles at beat 3.
        do_write({$urandom, $urandom}, rand_line(), 1, 8'b0000_1000, 4, 1'b0);
        idle(1);

        // Reset after read beat 4, then a clean read.
        do_read(64'h3000, rand_line(), 0, 8'h00, 1'b0, 5);
        idle(2);
        do_read(64'h3080, rand_line(), 2, 8'h00, 1'b1, 8);
        idle(1);

        // Back-to-back: request held through read completion, write follows immediately.
        do_read(64'h4000, rand_line(), 1, 8'h00, 1'b1, 8);
        do_write(64'h5000, rand_line(), 0, 8'h00, 0, 1'b1);
        idle(4);

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_write({$urandom, $urandom}, rand_line(), $urandom_range(0, 4), 8'h00, 0, 1'b1);
            else
                do_read({$urandom, $urandom}, rand_line(), $urandom_range(0, 4), 8'h00, 1'b1, 8);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
